// File: rtl/pattern_generator.sv
// Video test-pattern generator: colour bars, crosshatch, ramp, checker, solid and
// bouncing box, with a fixed two-cycle pixel pipeline and per-frame mode latching.
module pattern_generator #(
    parameter int H_RESOLUTION = 640,
    parameter int V_RESOLUTION = 480,
    parameter int COLOR_BITS   = 8,
    parameter int BOX_SIZE     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_disp_enable,
    input  logic [12:0]             x,
    input  logic [12:0]             y,
    input  logic                    i_frame_start,
    input  logic [2:0]              i_mode,
    input  logic [3*COLOR_BITS-1:0] i_solid_rgb,
    output logic [3*COLOR_BITS-1:0] o_rgb,
    output logic                    o_de,
    output logic [15:0]             o_frame_count
);
    localparam int CW = 3 * COLOR_BITS;
    localparam int PW = 14 + COLOR_BITS;

    localparam logic [12:0] H_RES  = 13'(H_RESOLUTION);
    localparam logic [12:0] V_RES  = 13'(V_RESOLUTION);
    localparam logic [12:0] H_LAST = 13'(H_RESOLUTION - 1);
    localparam logic [12:0] V_LAST = 13'(V_RESOLUTION - 1);
    localparam logic [12:0] BX_MAX = 13'(H_RESOLUTION - BOX_SIZE);
    localparam logic [12:0] BY_MAX = 13'(V_RESOLUTION - BOX_SIZE);
    localparam logic [12:0] BAR_W  = 13'(H_RESOLUTION / 8);
    localparam logic [13:0] BOX_W  = 14'(BOX_SIZE);
    localparam logic [PW-1:0] H_WIDE = PW'(H_RESOLUTION);
    localparam logic [PW-1:0] C_MAX  = PW'((1 << COLOR_BITS) - 1);

    localparam logic [COLOR_BITS-1:0] ON  = {COLOR_BITS{1'b1}};
    localparam logic [COLOR_BITS-1:0] OFF = '0;
    localparam logic [CW-1:0] WHITE   = {ON,  ON,  ON };
    localparam logic [CW-1:0] YELLOW  = {OFF, ON,  ON };
    localparam logic [CW-1:0] CYAN    = {ON,  ON,  OFF};
    localparam logic [CW-1:0] GREEN   = {OFF, ON,  OFF};
    localparam logic [CW-1:0] MAGENTA = {ON,  OFF, ON };
    localparam logic [CW-1:0] RED     = {OFF, OFF, ON };
    localparam logic [CW-1:0] BLUE    = {ON,  OFF, OFF};
    localparam logic [CW-1:0] BLACK   = '0;

    typedef enum logic {FWD, REV} dir_t;

    logic [2:0]    mode_q;
    logic [CW-1:0] solid_q;
    logic [15:0]   frame_cnt;
    logic [12:0]   bx, by;
    dir_t          dir_x, dir_y;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] rgb_p1;
    logic [CW-1:0] pix_rgb;

    logic [12:0]         bar_idx;
    logic [PW-1:0]       ramp_prod, ramp_quot;
    logic [COLOR_BITS-1:0] ramp_c;
    logic                hatch, checker_on, in_box;

    assign bar_idx    = x / BAR_W;
    assign ramp_prod  = {1'b0, x, {COLOR_BITS{1'b0}}};
    assign ramp_quot  = ramp_prod / H_WIDE;
    assign ramp_c     = (ramp_quot > C_MAX) ? ON : ramp_quot[COLOR_BITS-1:0];
    assign hatch      = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == H_LAST) || (y == V_LAST);
    assign checker_on = ~(x[4] ^ y[4] ^ frame_cnt[5]);
    assign in_box     = (x >= bx) && ({1'b0, x} < ({1'b0, bx} + BOX_W)) &&
                        (y >= by) && ({1'b0, y} < ({1'b0, by} + BOX_W));

    // Everything here reads the pre-update registers, so a pixel sampled together
    // with i_frame_start still sees the previous frame's mode/colour/box.
    always_comb begin
        pix_rgb = BLACK;
        if (i_disp_enable && (x < H_RES) && (y < V_RES)) begin
            case (mode_q)
                3'd0: begin
                    case (bar_idx)
                        13'd0:   pix_rgb = WHITE;
                        13'd1:   pix_rgb = YELLOW;
                        13'd2:   pix_rgb = CYAN;
                        13'd3:   pix_rgb = GREEN;
                        13'd4:   pix_rgb = MAGENTA;
                        13'd5:   pix_rgb = RED;
                        13'd6:   pix_rgb = BLUE;
                        default: pix_rgb = BLACK;
                    endcase
                end
                3'd1:    pix_rgb = hatch ? WHITE : BLACK;
                3'd2:    pix_rgb = {ramp_c, ramp_c, ramp_c};
                3'd3:    pix_rgb = checker_on ? WHITE : BLACK;
                3'd4:    pix_rgb = solid_q;
                3'd5:    pix_rgb = in_box ? WHITE : BLACK;
                default: pix_rgb = BLACK;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q    <= '0;
            solid_q   <= '0;
            frame_cnt <= '0;
            bx        <= '0;
            by        <= '0;
            dir_x     <= FWD;
            dir_y     <= FWD;
            vld_pipe  <= '0;
            rgb_p1    <= '0;
            o_rgb     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], i_disp_enable};
            rgb_p1   <= pix_rgb;
            o_rgb    <= vld_pipe[0] ? rgb_p1 : BLACK;
            if (i_frame_start) begin
                mode_q    <= i_mode;
                solid_q   <= i_solid_rgb;
                frame_cnt <= frame_cnt + 16'd1;
                // Box bounces between 0 and the last position that keeps it on screen.
                if (dir_x == FWD) begin
                    if (bx < BX_MAX) bx <= bx + 13'd1;
                    else begin dir_x <= REV; bx <= bx - 13'd1; end
                end else begin
                    if (bx > 13'd0) bx <= bx - 13'd1;
                    else begin dir_x <= FWD; bx <= bx + 13'd1; end
                end
                if (dir_y == FWD) begin
                    if (by < BY_MAX) by <= by + 13'd1;
                    else begin dir_y <= REV; by <= by - 13'd1; end
                end else begin
                    if (by > 13'd0) by <= by - 13'd1;
                    else begin dir_y <= FWD; by <= by + 13'd1; end
                end
            end
        end
    end

    assign o_de          = vld_pipe[1];
    assign o_frame_count = frame_cnt;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: expected colours computed by hand for the
// default 640x480, 8-bit, 32-pixel-box configuration.
module tb_pattern_generator;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_disp_enable;
    logic [12:0] x, y;
    logic        i_frame_start;
    logic [2:0]  i_mode;
    logic [23:0] i_solid_rgb;
    logic [23:0] o_rgb;
    logic        o_de;
    logic [15:0] o_frame_count;

    int tests = 0;
    int fails = 0;
    int fc    = 0;

    pattern_generator dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_disp_enable (i_disp_enable),
        .x             (x),
        .y             (y),
        .i_frame_start (i_frame_start),
        .i_mode        (i_mode),
        .i_solid_rgb   (i_solid_rgb),
        .o_rgb         (o_rgb),
        .o_de          (o_de),
        .o_frame_count (o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic de, input int xx, input int yy);
        i_disp_enable = de;
        x = 13'(xx);
        y = 13'(yy);
    endtask

    // Single isolated pixel: result lands two edges after it is presented.
    task automatic check_pix(input string tag, input int xx, input int yy, input logic [23:0] exp);
        drive(1'b1, xx, yy);
        tick();
        drive(1'b0, 0, 0);
        tick();
        chk({tag, "_de"}, 32'(o_de), 32'd1);
        chk(tag, 32'(o_rgb), 32'(exp));
    endtask

    task automatic set_mode(input logic [2:0] m, input logic [23:0] solid);
        i_mode = m;
        i_solid_rgb = solid;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        fc++;
    endtask

    task automatic pulses(input int n);
        i_frame_start = 1'b1;
        repeat (n) tick();
        i_frame_start = 1'b0;
        fc += n;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        fc = 0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive(1'b0, 0, 0);
        i_frame_start = 1'b0;
        i_mode = 3'd0;
        i_solid_rgb = 24'h0;
        #12;
        chk("rst_de", 32'(o_de), 32'd0);
        chk("rst_rgb", 32'(o_rgb), 32'd0);
        chk("rst_fc", 32'(o_frame_count), 32'd0);
        tick();
        i_rst_n = 1'b1;

        // Right after release: mode 0 from reset, two-cycle latency, no stale data
        drive(1'b1, 0, 0);
        tick();
        chk("lat1_de", 32'(o_de), 32'd0);
        drive(1'b1, 80, 0);
        tick();
        chk("lat2_de", 32'(o_de), 32'd1);
        chk("bar_x0", 32'(o_rgb), 32'hFFFFFF);
        drive(1'b0, 0, 0);
        tick();
        chk("bar_x80", 32'(o_rgb), 32'h00FFFF);
        tick();
        chk("de_drop", 32'(o_de), 32'd0);
        chk("de_drop_rgb", 32'(o_rgb), 32'd0);

        set_mode(3'd0, 24'h0);
        chk("fc_1", 32'(o_frame_count), 32'(fc));
        check_pix("bar_x79",  79,  0, 24'hFFFFFF);
        check_pix("bar_x160", 160, 0, 24'hFFFF00);
        check_pix("bar_x240", 240, 0, 24'h00FF00);
        check_pix("bar_x320", 320, 0, 24'hFF00FF);
        check_pix("bar_x400", 400, 0, 24'h0000FF);
        check_pix("bar_x559", 559, 0, 24'hFF0000);
        check_pix("bar_x560", 560, 0, 24'h000000);
        check_pix("bar_x639", 639, 0, 24'h000000);
        set_mode(3'd3, 24'h0);
        check_pix("oob_x640", 640, 0, 24'h000000);
        check_pix("oob_y480", 0, 480, 24'h000000);

        set_mode(3'd1, 24'h0);
        check_pix("hatch_32_5",  32,  5,  24'hFFFFFF);
        check_pix("hatch_33_5",  33,  5,  24'h000000);
        check_pix("hatch_639_5", 639, 5,  24'hFFFFFF);
        check_pix("hatch_5_479", 5,   479, 24'hFFFFFF);
        check_pix("hatch_5_63",  5,   63, 24'h000000);
        check_pix("hatch_5_64",  5,   64, 24'hFFFFFF);

        set_mode(3'd2, 24'h0);
        check_pix("ramp_0",   0,   7, 24'h000000);
        check_pix("ramp_160", 160, 7, 24'h404040);
        check_pix("ramp_320", 320, 7, 24'h808080);
        check_pix("ramp_639", 639, 7, 24'hFFFFFF);

        set_mode(3'd3, 24'h0);
        check_pix("chk_0_0",   0,  0,  24'hFFFFFF);
        check_pix("chk_16_0",  16, 0,  24'h000000);
        check_pix("chk_16_16", 16, 16, 24'hFFFFFF);
        check_pix("chk_15_16", 15, 16, 24'h000000);

        set_mode(3'd4, 24'h123456);
        check_pix("solid", 10, 10, 24'h123456);
        set_mode(3'd6, 24'h123456);
        check_pix("mode6", 0, 0, 24'h000000);
        set_mode(3'd7, 24'h123456);
        check_pix("mode7", 0, 0, 24'h000000);

        // Mode switch mid-line: pixel sampled with frame_start keeps the old mode
        set_mode(3'd1, 24'h0);
        drive(1'b1, 99, 0);
        tick();
        drive(1'b1, 100, 0);
        i_mode = 3'd4;
        i_solid_rgb = 24'hABCDEF;
        i_frame_start = 1'b1;
        tick();
        fc++;
        i_frame_start = 1'b0;
        chk("sw_x99", 32'(o_rgb), 32'hFFFFFF);
        drive(1'b1, 101, 0);
        tick();
        chk("sw_x100", 32'(o_rgb), 32'hFFFFFF);
        drive(1'b0, 0, 0);
        tick();
        chk("sw_x101", 32'(o_rgb), 32'hABCDEF);
        chk("fc_mid", 32'(o_frame_count), 32'(fc));

        // Asynchronous reset mid-line, checked before any further clock edge
        drive(1'b1, 200, 0);
        tick();
        tick();
        chk("pre_arst_de", 32'(o_de), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_de", 32'(o_de), 32'd0);
        chk("arst_rgb", 32'(o_rgb), 32'd0);
        chk("arst_fc", 32'(o_frame_count), 32'd0);
        drive(1'b0, 0, 0);
        tick();
        i_rst_n = 1'b1;
        fc = 0;

        // Bouncing box: 608 pulses -> bx=608, by=288; one more -> bx=607, by=287
        set_mode(3'd5, 24'h0);
        pulses(607);
        check_pix("box_608_288", 608, 288, 24'hFFFFFF);
        check_pix("box_607_288", 607, 288, 24'h000000);
        check_pix("box_639_319", 639, 319, 24'hFFFFFF);
        check_pix("box_639_320", 639, 320, 24'h000000);
        pulses(1);
        check_pix("box_607_287", 607, 287, 24'hFFFFFF);
        check_pix("box_639_287", 639, 287, 24'h000000);
        check_pix("box_606_287", 606, 287, 24'h000000);
        check_pix("box_638_318", 638, 318, 24'hFFFFFF);
        check_pix("box_607_319", 607, 319, 24'h000000);
        chk("fc_609", 32'(o_frame_count), 32'(fc));

        // Checker phase flip at count 32, then counter wrap
        do_reset();
        set_mode(3'd3, 24'h0);
        pulses(30);
        chk("fc_31", 32'(o_frame_count), 32'd31);
        check_pix("phase_31", 0, 0, 24'hFFFFFF);
        pulses(1);
        check_pix("phase_32",    0,  0, 24'h000000);
        check_pix("phase_32_16", 16, 0, 24'hFFFFFF);
        pulses(65503);
        chk("fc_ffff", 32'(o_frame_count), 32'h0000FFFF);
        pulses(1);
        chk("fc_wrap", 32'(o_frame_count), 32'd0);
        check_pix("phase_wrap", 0, 0, 24'hFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
